acc_channel_bank: RTL and testbench

ACC_CHANNEL_BANK -- requirements
Module: acc_channel_bank

---
 rtl/acc_pkg.sv | 25 ++
 rtl/acc_sat_add.sv | 41 ++++
 rtl/acc_channel_bank.sv | 162 ++++++++++++++++
 tb/tb_acc_channel_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared types and helpers for the accumulator channel bank.
//   out_state_e      - state of the single-entry result register (EMPTY/FULL)
//   acc_smax(w)      - most positive two's-complement value at width w
//   acc_smin(w)      - most negative two's-complement value at width w
// The helpers return 64-bit values; callers size-cast to the width they need
// (valid for widths 1..64).
package acc_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  localparam int unsigned ACC_MAX_W = 64;

  function automatic logic [ACC_MAX_W-1:0] acc_smax(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Lower w bits of ~smax are 1000...0, i.e. the most negative value.
  function automatic logic [ACC_MAX_W-1:0] acc_smin(input int unsigned w);
    return ~acc_smax(w);
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// acc_sat_add: W-bit signed add/subtract with overflow detection and optional
// saturation.
//   a_i    [W-1:0]  accumulator operand (two's complement)
//   b_i    [W-1:0]  sample operand, already sign-extended to W
//   sub_i           1 = a - b, 0 = a + b
//   sum_o  [W-1:0]  clamped (SATURATE=1) or wrapped (SATURATE=0) result
//   ovf_o           true signed result does not fit in W bits
module acc_sat_add
  import acc_pkg::*;
#(
  parameter int W        = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  // Two guard bits: negating the most negative b and then adding it to the
  // most negative/positive a stays exact, so no operand is ever truncated.
  logic [W+1:0] a_x;
  logic [W+1:0] b_x;
  logic [W+1:0] s_x;
  logic [2:0]   top;

  always_comb begin
    a_x   = {{2{a_i[W-1]}}, a_i};
    b_x   = {{2{b_i[W-1]}}, b_i};
    s_x   = sub_i ? (a_x - b_x) : (a_x + b_x);
    top   = s_x[W+1:W-1];
    // Result fits in W bits only when the top three bits all agree.
    ovf_o = !((&top) || (~|top));
    sum_o = s_x[W-1:0];
    if (SATURATE && ovf_o) begin
      sum_o = s_x[W+1] ? W'(acc_smin(W)) : W'(acc_smax(W));
    end
  end

endmodule

// File: rtl/acc_channel_bank.sv
// acc_channel_bank: N_CH independent windowed accumulators sharing one
// saturating adder. Each accepted sample is added to (or subtracted from) its
// channel's sum; on the WIN_LEN-th sample the window result is loaded into a
// single-entry output register and the channel restarts from zero.
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           sample handshake (in_ready = !out_valid || out_ready)
//   in_ch  [log2(N_CH)-1:0]     target channel
//   in_sign                     1 = subtract sample, 0 = add
//   in_init                     1 = start a new window with this sample
//   in_data [BIT_WIDTH-1:0]     two's-complement sample
//   out_valid/out_ready         result handshake
//   out_ch  [log2(N_CH)-1:0]    channel of the result
//   out_data [ACC_WIDTH-1:0]    window sum
//   out_ovf                     overflow seen somewhere in the window
module acc_channel_bank
  import acc_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int ACC_WIDTH = 24,
  parameter int N_CH      = 4,
  parameter int WIN_LEN   = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(N_CH)-1:0] in_ch,
  input  logic                    in_sign,
  input  logic                    in_init,
  input  logic [BIT_WIDTH-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic [ACC_WIDTH-1:0]    out_data,
  output logic                    out_ovf
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(WIN_LEN);

  // Per-channel state
  logic [ACC_WIDTH-1:0] acc_q [N_CH];
  logic [ACC_WIDTH-1:0] acc_d [N_CH];
  logic [CNT_W-1:0]     cnt_q [N_CH];
  logic [CNT_W-1:0]     cnt_d [N_CH];
  logic                 ovf_q [N_CH];
  logic                 ovf_d [N_CH];

  // Output register
  out_state_e           state_q, state_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;

  // Datapath for the addressed channel
  logic                 accept;
  logic                 last;
  logic [ACC_WIDTH-1:0] acc_sel;
  logic [CNT_W-1:0]     cnt_sel;
  logic                 ovf_sel;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 add_ovf;
  logic                 new_ovf;
  logic signed [BIT_WIDTH-1:0] data_s;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    data_s  = in_data;
    ext     = ACC_WIDTH'(data_s);
    // in_init behaves as if the channel had just been cleared.
    acc_sel = in_init ? '0 : acc_q[in_ch];
    cnt_sel = in_init ? '0 : cnt_q[in_ch];
    ovf_sel = in_init ? 1'b0 : ovf_q[in_ch];
    last    = (cnt_sel == CNT_W'(WIN_LEN - 1));
    new_ovf = ovf_sel || add_ovf;
  end

  acc_sat_add #(
    .W       (ACC_WIDTH),
    .SATURATE(SATURATE)
  ) u_add (
    .a_i  (acc_sel),
    .b_i  (ext),
    .sub_i(in_sign),
    .sum_o(sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      acc_d[c] = acc_q[c];
      cnt_d[c] = cnt_q[c];
      ovf_d[c] = ovf_q[c];
    end
    if (accept) begin
      if (last) begin
        acc_d[in_ch] = '0;
        cnt_d[in_ch] = '0;
        ovf_d[in_ch] = 1'b0;
      end else begin
        acc_d[in_ch] = sum;
        cnt_d[in_ch] = cnt_sel + CNT_W'(1);
        ovf_d[in_ch] = new_ovf;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_ch_d   = out_ch_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      EMPTY: begin
        if (accept && last) state_d = FULL;
      end
      FULL: begin
        // A completion here implies out_ready (accept needs in_ready), so
        // the old entry is consumed and replaced in the same edge.
        if (accept && last) state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept && last) begin
      out_ch_d   = in_ch;
      out_data_d = sum;
      out_ovf_d  = new_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
        ovf_q[c] <= 1'b0;
      end
      state_q    <= EMPTY;
      out_ch_q   <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      out_ch_q   <= out_ch_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_acc_channel_bank.sv
// Directed bench for acc_channel_bank: default-parameter instance checked by a
// result scoreboard, plus two 16-bit-accumulator instances (saturate / wrap)
// fed the same stimulus for the overflow cases.
module tb_acc_channel_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ch = '0;
  logic        in_sign = 1'b0;
  logic        in_init = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf;
  logic [1:0]  out_ch;
  logic [23:0] out_data;

  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [1:0]  s_out_ch;
  logic [15:0] s_out_data;
  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [1:0]  w_out_ch;
  logic [15:0] w_out_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [23:0] data;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  acc_channel_bank #(
    .BIT_WIDTH(16), .ACC_WIDTH(24), .N_CH(4), .WIN_LEN(8), .SATURATE(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_sign(in_sign), .in_init(in_init), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  acc_channel_bank #(
    .BIT_WIDTH(16), .ACC_WIDTH(16), .N_CH(4), .WIN_LEN(8), .SATURATE(1'b1)
  ) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ch(in_ch), .in_sign(in_sign), .in_init(in_init), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ch(s_out_ch),
    .out_data(s_out_data), .out_ovf(s_out_ovf)
  );

  acc_channel_bank #(
    .BIT_WIDTH(16), .ACC_WIDTH(16), .N_CH(4), .WIN_LEN(8), .SATURATE(1'b0)
  ) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_ch(in_ch), .in_sign(in_sign), .in_init(in_init), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_ch(w_out_ch),
    .out_data(w_out_data), .out_ovf(w_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [23:0] data, input logic ovf);
    exp_t e;
    e.ch = ch; e.data = data; e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Offer one sample; returns #1 after the edge on which it was accepted.
  task automatic send(input logic [1:0] ch, input logic sgn, input logic init,
                      input logic [15:0] d);
    int n = 0;
    in_ch = ch; in_sign = sgn; in_init = init; in_data = d; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_init = 1'b0; in_sign = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Every consumed result is compared against the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_ch", 32'(out_ch), 32'(e.ch));
        chk("res_data", 32'(out_data), 32'(e.data));
        chk("res_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    // Reset state
    rst = 1'b1;
    idle(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    idle(1);

    // Eight +1 samples on channel 0
    push_exp(2'd0, 24'd8, 1'b0);
    for (int i = 0; i < 8; i++) send(2'd0, 1'b0, 1'b0, 16'd1);
    chk("win_out_valid", 32'(out_valid), 32'd1);
    idle(2);
    chk("acc0_cleared", 32'(u_dut.acc_q[0]), 32'd0);
    chk("cnt0_cleared", 32'(u_dut.cnt_q[0]), 32'd0);

    // Interleaved channels, channel c fed value c
    push_exp(2'd0, 24'd0, 1'b0);
    push_exp(2'd1, 24'd8, 1'b0);
    push_exp(2'd2, 24'd16, 1'b0);
    push_exp(2'd3, 24'd24, 1'b0);
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 4; c++) send(2'(c), 1'b0, 1'b0, 16'(c));
    idle(4);

    // Overflow: 8 x 0x7FFF on channel 1
    rst = 1'b1; idle(1); rst = 1'b0;
    push_exp(2'd1, 24'h03FFF8, 1'b0);
    for (int i = 0; i < 8; i++) send(2'd1, 1'b0, 1'b0, 16'h7FFF);
    chk("sat_valid", 32'(s_out_valid), 32'd1);
    chk("sat_ch", 32'(s_out_ch), 32'd1);
    chk("sat_data", 32'(s_out_data), 32'h7FFF);
    chk("sat_ovf", 32'(s_out_ovf), 32'd1);
    chk("wrap_data", 32'(w_out_data), 32'hFFF8);
    chk("wrap_ovf", 32'(w_out_ovf), 32'd1);
    idle(2);

    // Subtracting the most negative sample is +32768, exact at 24 bits
    push_exp(2'd2, 24'h040000, 1'b0);
    for (int i = 0; i < 8; i++) send(2'd2, 1'b1, 1'b0, 16'h8000);
    push_exp(2'd3, 24'hFFFFE8, 1'b0);
    for (int i = 0; i < 8; i++) send(2'd3, 1'b1, 1'b0, 16'd3);
    idle(2);

    // Backpressure: stall a result, then release it as another window completes
    for (int i = 0; i < 7; i++) send(2'd1, 1'b0, 1'b0, 16'd3);
    out_ready = 1'b0;
    push_exp(2'd0, 24'd16, 1'b0);
    push_exp(2'd1, 24'd24, 1'b0);
    for (int i = 0; i < 8; i++) send(2'd0, 1'b0, 1'b0, 16'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    in_ch = 2'd1; in_data = 16'd3; in_sign = 1'b0; in_init = 1'b0; in_valid = 1'b1;
    idle(3);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'd16);
    chk("stall_ch", 32'(out_ch), 32'd0);
    chk("stall_cnt1", 32'(u_dut.cnt_q[1]), 32'd7);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("reload_valid", 32'(out_valid), 32'd1);
    chk("reload_ch", 32'(out_ch), 32'd1);
    chk("reload_data", 32'(out_data), 32'd24);
    idle(2);

    // in_init mid-window discards the partial sum
    push_exp(2'd2, 24'd5, 1'b0);
    for (int i = 0; i < 3; i++) send(2'd2, 1'b0, 1'b0, 16'd5);
    send(2'd2, 1'b0, 1'b1, 16'hFFFE);
    chk("init_cnt2", 32'(u_dut.cnt_q[2]), 32'd1);
    for (int i = 0; i < 7; i++) send(2'd2, 1'b0, 1'b0, 16'd1);
    idle(2);

    // Reset mid-window and with a stalled result pending
    for (int i = 0; i < 4; i++) send(2'd3, 1'b0, 1'b0, 16'd9);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(2'd0, 1'b0, 1'b0, 16'd1);
    chk("pend_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    idle(1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    chk("mrst_out_ch", 32'(out_ch), 32'd0);
    chk("mrst_out_ovf", 32'(out_ovf), 32'd0);
    chk("mrst_acc3", 32'(u_dut.acc_q[3]), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(1);
    push_exp(2'd3, 24'd8, 1'b0);
    for (int i = 0; i < 7; i++) send(2'd3, 1'b0, 1'b0, 16'd1);
    chk("mrst_no_early", 32'(out_valid), 32'd0);
    send(2'd3, 1'b0, 1'b0, 16'd1);
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
